// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave that emulates a single-channel ADC answering 24-bit read frames
// (8-bit command, 16-bit sample), with Wishbone-programmable samples, ramp and irq.
module spi_adc_responder #(
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [15:0] DEFAULT_STEP = 16'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic                  wb_stb,
  output logic                  wb_ack,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  irq
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_CH0    = 6'h02;
  localparam logic [5:0] REG_STEP   = 6'h06;
  localparam logic [5:0] REG_XFER   = 6'h07;
  localparam logic [5:0] REG_LAST   = 6'h08;

  // Pad synchronizers; CS idles high so its chain resets to deselected.
  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic       sck_prev_q, cs_prev_q;
  logic       sck_fall, cs_fall, cs_rise, mosi_s;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_shift_q, cmd_shift_d, cmd_word;
  logic [15:0] tx_shift_q, tx_shift_d;
  logic [1:0]  chan_q;
  logic        valid_q;
  logic        cmd_done, xfer_done, abort_evt;
  logic        xfer_done_q, irq_q;

  logic [2:0]  ctrl_q;
  logic [15:0] sample_q [4];
  logic [15:0] step_q, xfer_cnt_q;
  logic [7:0]  last_cmd_q;
  logic        cmd_err_q, abort_q;
  logic [3:0]  read_flag_q, flag_set;
  logic        wb_ack_q;
  logic [31:0] wb_dat_q, rd_data;
  logic        bus_cycle, bus_wr, ramp_upd;
  logic [5:0]  reg_idx;
  logic [7:0]  status_w1c;
  logic        unused_inputs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sck_prev_q  <= sck_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sck_fall = sck_prev_q & ~sck_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_sync_q[1];
  assign cs_rise  = ~cs_prev_q & cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cmd_word = {cmd_shift_q[6:0], mosi_s};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_shift_d = cmd_shift_q;
    tx_shift_d  = tx_shift_q;
    cmd_done    = 1'b0;
    xfer_done   = 1'b0;
    abort_evt   = 1'b0;
    unique case (state_q)
      IDLE: if (cs_fall && ctrl_q[0]) begin
        state_d   = CMD;
        bit_cnt_d = '0;
      end
      CMD: if (!ctrl_q[0] || cs_rise) begin
        abort_evt = 1'b1;
        state_d   = IDLE;
      end else if (sck_fall) begin
        cmd_shift_d = cmd_word;
        bit_cnt_d   = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          cmd_done   = 1'b1;
          bit_cnt_d  = '0;
          state_d    = DATA;
          tx_shift_d = cmd_word[7] ? sample_q[cmd_word[6:5]] : 16'h0000;
        end
      end
      DATA: if (!ctrl_q[0] || cs_rise) begin
        abort_evt = 1'b1;
        state_d   = IDLE;
      end else if (sck_fall) begin
        tx_shift_d = {tx_shift_q[14:0], 1'b0};
        bit_cnt_d  = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) state_d = DONE;
      end
      DONE: if (!ctrl_q[0]) begin
        abort_evt = 1'b1;
        state_d   = IDLE;
      end else if (cs_rise) begin
        xfer_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_shift_q <= '0;
      tx_shift_q  <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      xfer_done_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_shift_q <= cmd_shift_d;
      tx_shift_q  <= tx_shift_d;
      if (cmd_done) begin
        chan_q  <= cmd_word[6:5];
        valid_q <= cmd_word[7];
      end
      xfer_done_q <= xfer_done;
      irq_q       <= xfer_done_q & ctrl_q[2];
    end
  end

  assign bus_cycle  = wb_stb & ~wb_ack_q;
  assign bus_wr     = bus_cycle & wb_we;
  assign reg_idx    = wb_addr[7:2];
  assign status_w1c = (bus_wr && reg_idx == REG_STATUS) ? wb_dat_i[7:0] : 8'h00;
  assign ramp_upd   = xfer_done & valid_q & ctrl_q[1];
  assign flag_set   = (xfer_done && valid_q) ? (4'b0001 << chan_q) : 4'b0000;

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL:   rd_data[2:0]  = ctrl_q;
      REG_STATUS: rd_data[7:0]  = {read_flag_q, 1'b0, abort_q, cmd_err_q, state_q != IDLE};
      6'h02:      rd_data[15:0] = sample_q[0];
      6'h03:      rd_data[15:0] = sample_q[1];
      6'h04:      rd_data[15:0] = sample_q[2];
      6'h05:      rd_data[15:0] = sample_q[3];
      REG_STEP:   rd_data[15:0] = step_q;
      REG_XFER:   rd_data[15:0] = xfer_cnt_q;
      REG_LAST:   rd_data[7:0]  = last_cmd_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      step_q      <= DEFAULT_STEP;
      xfer_cnt_q  <= '0;
      last_cmd_q  <= '0;
      cmd_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      read_flag_q <= '0;
      wb_ack_q    <= 1'b0;
      wb_dat_q    <= '0;
      // NOTE: the sample bank is a handful of flops with defined reset values, so it is reset like any register.
      for (int i = 0; i < 4; i++) sample_q[i] <= '0;
    end else begin
      wb_ack_q <= bus_cycle;
      if (bus_cycle && !wb_we) wb_dat_q <= rd_data;
      if (bus_wr && reg_idx == REG_CTRL) ctrl_q <= wb_dat_i[2:0];
      if (bus_wr && reg_idx == REG_STEP) step_q <= wb_dat_i[15:0];
      if (cmd_done) last_cmd_q <= cmd_word;
      if (xfer_done) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      cmd_err_q   <= (cmd_err_q & ~status_w1c[1]) | (cmd_done & ~cmd_word[7]);
      abort_q     <= (abort_q & ~status_w1c[2]) | abort_evt;
      read_flag_q <= (read_flag_q & ~status_w1c[7:4]) | flag_set;
      // NOTE: non-blocking, so the later bus write overrides a same-cycle ramp update.
      for (int i = 0; i < 4; i++) begin
        if (ramp_upd && chan_q == 2'(i)) sample_q[i] <= sample_q[i] + step_q;
        if (bus_wr && reg_idx == REG_CH0 + 6'(i)) sample_q[i] <= wb_dat_i[15:0];
      end
    end
  end

  assign wb_ack      = wb_ack_q;
  assign wb_dat_o    = wb_dat_q;
  assign irq         = irq_q;
  assign spi_miso    = (state_q == DATA) & tx_shift_q[15] & ctrl_q[0];
  assign spi_miso_oe = (state_q != IDLE) & ctrl_q[0];

  assign unused_inputs = ^{wb_sel, wb_addr[1:0], wb_dat_i[31:16]};

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a bus driver and SPI master issue directed stimulus and
// queue expected read data / frames; monitors pop and compare as the DUT answers.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_stb = 1'b0;
  logic        wb_ack;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        bus_q[$];
  logic [23:0] spi_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cs_rise_cyc = 0;
  int          irq_cyc = 0;
  int          irq_rises = 0;
  int          irq_hi = 0;
  logic        irq_prev = 1'b0;
  bit          rd_pending = 1'b0;
  int          spi_bits = 0;
  logic [23:0] spi_rx = '0;
  bit          spi_skip = 1'b0;

  spi_adc_responder #(.ADDR_WIDTH(8), .DEFAULT_STEP(16'd1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_addr(wb_addr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_ack(wb_ack),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 30000) begin
      $display("FAIL watchdog: cycle budget exceeded at cycle %0d (limit 30000)", cyc);
      $fatal(1, "timeout");
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus read monitor: compares registered read data against the queued expectation.
  always @(negedge clk) begin
    if (wb_ack && rd_pending) begin
      rd_pending = 1'b0;
      if (bus_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL bus_unexpected: read 0x%08h with nothing queued", wb_dat_o);
      end else begin
        exp_t e;
        e = bus_q.pop_front();
        check(e.name, wb_dat_o, e.val);
      end
    end
  end

  // SPI monitor: master-side sampling of MISO on SCK rise; a full 24-bit frame is scored.
  always @(negedge spi_cs_n) begin
    spi_bits = 0;
    spi_skip = 1'b0;
  end
  always @(negedge rst_n) spi_skip = 1'b1;
  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      spi_rx = {spi_rx[22:0], spi_miso};
      spi_bits++;
      if (spi_bits == 24 && !spi_skip) begin
        if (spi_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spi_unexpected: frame 0x%06h with nothing queued", spi_rx);
        end else begin
          check("spi_frame", {8'h00, spi_rx}, {8'h00, spi_q.pop_front()});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (irq) begin
      irq_hi++;
      if (!irq_prev) begin
        irq_rises++;
        irq_cyc = cyc;
      end
    end
    irq_prev = irq;
  end

  task automatic wb_write(input logic [7:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1 wb_addr = addr; wb_dat_i = data; wb_we = 1'b1; wb_stb = 1'b1;
    @(posedge clk);
    #1 wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.val  = exp;
    bus_q.push_back(e);
    @(posedge clk);
    #1 wb_addr = addr; wb_we = 1'b0; wb_stb = 1'b1; rd_pending = 1'b1;
    @(posedge clk);
    #1 wb_stb = 1'b0;
  endtask

  // SCK half-period 5 clk; MOSI changes 2 clk into the low phase, well clear of the fall.
  task automatic spi_frame(input logic [7:0] cmd, input int nsck);
    @(posedge clk);
    #1 spi_cs_n = 1'b0;
    for (int i = 0; i < nsck; i++) begin
      repeat (2) @(posedge clk);
      #1 spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
      repeat (3) @(posedge clk);
      #1 spi_sck = 1'b1;
      repeat (5) @(posedge clk);
      #1 spi_sck = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1 spi_cs_n = 1'b1; cs_rise_cyc = cyc;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_ack", wb_ack, 0);
    check("rst_wb_dat_o", wb_dat_o, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_irq", irq, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    wb_read("rst_ctrl", 8'h00, 32'h0);
    wb_read("rst_status", 8'h04, 32'h0);
    wb_read("rst_step", 8'h18, 32'h1);
    wb_read("rst_xfer", 8'h1C, 32'h0);
    wb_read("rst_last", 8'h20, 32'h0);
    wb_read("rst_ch2", 8'h10, 32'h0);
    wb_read("unmapped", 8'h24, 32'h0);

    // Basic ch2 read.
    wb_write(8'h10, 32'hA5C3);
    wb_write(8'h00, 32'h1);
    spi_q.push_back(24'h00A5C3);
    fork
      spi_frame(8'hC0, 24);
      begin
        repeat (100) @(posedge clk);
        #1 check("oe_selected", spi_miso_oe, 1);
      end
    join
    wb_read("t1_last", 8'h20, 32'hC0);
    wb_read("t1_status", 8'h04, 32'h40);
    wb_read("t1_xfer", 8'h1C, 32'h1);

    // Ramp with wrap, irq enabled.
    wb_write(8'h00, 32'h7);
    wb_write(8'h18, 32'h10);
    wb_write(8'h08, 32'hFFF8);
    irq_rises = 0;
    irq_hi = 0;
    spi_q.push_back(24'h00FFF8);
    spi_frame(8'h80, 24);
    repeat (3) @(posedge clk);
    check("irq_latency", irq_cyc - cs_rise_cyc, 4);
    spi_q.push_back(24'h000008);
    spi_frame(8'h80, 24);
    repeat (3) @(posedge clk);
    check("irq_pulses", irq_rises, 2);
    check("irq_width", irq_hi, 2);
    wb_read("t2_ch0", 8'h08, 32'h18);
    wb_read("t2_xfer", 8'h1C, 32'h3);
    wb_read("t2_status", 8'h04, 32'h50);

    // Invalid command.
    spi_q.push_back(24'h000000);
    spi_frame(8'h40, 24);
    repeat (3) @(posedge clk);
    wb_read("t3_status", 8'h04, 32'h52);
    wb_read("t3_xfer", 8'h1C, 32'h4);
    wb_read("t3_last", 8'h20, 32'h40);
    wb_read("t3_ch0_noramp", 8'h08, 32'h18);
    check("t3_irq", irq_rises, 3);
    wb_write(8'h04, 32'h02);
    wb_read("t3_w1c", 8'h04, 32'h50);

    // Abort after 12 SCK, then a clean frame.
    spi_frame(8'h80, 12);
    check("abort_oe", spi_miso_oe, 0);
    repeat (3) @(posedge clk);
    wb_read("t4_status", 8'h04, 32'h54);
    wb_read("t4_xfer", 8'h1C, 32'h4);
    wb_read("t4_ch0", 8'h08, 32'h18);
    wb_read("t4_last", 8'h20, 32'h80);
    check("t4_irq", irq_rises, 3);
    spi_q.push_back(24'h000018);
    spi_frame(8'h80, 24);
    repeat (3) @(posedge clk);
    wb_read("t4_ch0_after", 8'h08, 32'h28);
    wb_read("t4_xfer_after", 8'h1C, 32'h5);
    check("t4_irq_after", irq_rises, 4);

    // Bus write during DATA does not disturb the snapshot.
    wb_write(8'h04, 32'hF6);
    wb_read("t5_status_clr", 8'h04, 32'h0);
    wb_write(8'h00, 32'h1);
    wb_write(8'h0C, 32'h1234);
    spi_q.push_back(24'h001234);
    fork
      spi_frame(8'hA0, 24);
      begin
        repeat (150) @(posedge clk);
        wb_write(8'h0C, 32'hFFFF);
      end
    join
    spi_q.push_back(24'h00FFFF);
    spi_frame(8'hA0, 24);
    wb_read("t5_ch1", 8'h0C, 32'hFFFF);
    wb_read("t5_status", 8'h04, 32'h20);

    // Reset mid-DATA.
    fork
      spi_frame(8'hA0, 24);
      begin
        repeat (150) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_miso", spi_miso, 0);
        check("t6_oe", spi_miso_oe, 0);
        check("t6_ack", wb_ack, 0);
        check("t6_dat_o", wb_dat_o, 0);
        check("t6_irq", irq, 0);
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    wb_read("t6_ctrl", 8'h00, 32'h0);
    wb_read("t6_ch1", 8'h0C, 32'h0);
    wb_read("t6_step", 8'h18, 32'h1);
    wb_read("t6_xfer", 8'h1C, 32'h0);
    wb_read("t6_last", 8'h20, 32'h0);
    wb_read("t6_status", 8'h04, 32'h0);

    // ENABLE=0: frame ignored.
    spi_q.push_back(24'h000000);
    fork
      spi_frame(8'h80, 24);
      begin
        repeat (100) @(posedge clk);
        #1 check("disabled_oe", spi_miso_oe, 0);
      end
    join
    wb_read("disabled_xfer", 8'h1C, 32'h0);
    wb_read("disabled_last", 8'h20, 32'h0);

    wb_write(8'h14, 32'h5A0F);
    wb_write(8'h00, 32'h1);
    spi_q.push_back(24'h005A0F);
    spi_frame(8'hE0, 24);
    wb_read("t6_xfer_after", 8'h1C, 32'h1);
    wb_read("t6_status_after", 8'h04, 32'h80);
    wb_read("t6_last_after", 8'h20, 32'hE0);

    repeat (5) @(posedge clk);
    check("bus_queue_drained", bus_q.size(), 0);
    check("spi_queue_drained", spi_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI slave (mode 0, CPOL=0/CPHA=0) that answers the 24-bit single-channel ADC read frame: an 8-bit command followed by 16 data bits. It stands in for the external ADC on the far end of the SPI link, and serves two purposes: a loopback/self-test target on the FPGA, and a model for bench verification of the SPI master peripheral. Sample values come from Wishbone-writable per-channel registers, with an optional ramp auto-increment. The block sits on the same Wishbone peripheral bus as the other peripherals.

## Interface
- ADDR_WIDTH, 8, Wishbone byte-address width
- DEFAULT_STEP, 1, reset value of RAMP_STEP
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_addr  in  ADDR_WIDTH  byte address; decode on [7:2]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_we  in  1  write strobe qualifier
- wb_sel  in  4  byte enables; ignored, full-word access only
- wb_stb  in  1  bus request
- wb_ack  out  1  acknowledge
- spi_sck  in  1  SPI clock from the master, asynchronous
- spi_cs_n  in  1  chip select, active low, asynchronous
- spi_mosi  in  1  command data from the master
- spi_miso  out  1  sample data to the master
- spi_miso_oe  out  1  MISO output enable; high while selected and ENABLE=1
- irq  out  1  one-cycle pulse on each completed transfer, gated by IRQ_EN

## Operation
- Synchronization:
  - spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer.
  - SCK rise/fall and CS fall/rise are detected from the synchronized value and its previous sample.
- Register map (address [7:2]):
  - 0x00 CTRL: [0] ENABLE, [1] RAMP, [2] IRQ_EN.
  - 0x04 STATUS: [0] BUSY (RO, state≠IDLE), [1] CMD_ERR, [2] ABORT, [7:4] READ_FLAG[3:0]. Bits [7:1] are sticky and write-1-to-clear.
  - 0x08/0x0C/0x10/0x14 SAMPLE_CH0..3: [15:0], read/write.
  - 0x18 RAMP_STEP: [15:0].
  - 0x1C XFER_COUNT: [15:0], RO, wraps 0xFFFF→0.
  - 0x20 LAST_CMD: [7:0], RO.
  - Unmapped addresses read 0.
- Wishbone handshake: wb_ack <= wb_stb && !wb_ack. Writes and reads act in the cycle where wb_stb=1 and wb_ack=0.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE→CMD on CS fall with ENABLE=1; bit counter cleared. With ENABLE=0 the frame is ignored and miso_oe stays 0.
  - CMD: capture synchronized MOSI on each SCK fall, MSB first, into an 8-bit shift register. After the 8th fall:
    - Store LAST_CMD.
    - Valid command (cmd[7]=1): channel = cmd[6:5]; tx_shift is loaded with the SAMPLE_CH[channel] snapshot.
    - Invalid command (cmd[7]=0): tx_shift = 0 and CMD_ERR is set.
    - spi_miso is driven with tx_shift[15]. Go to DATA.
  - DATA: on each SCK fall, shift tx_shift left and drive the new bit [15]. After the 16th fall go to DONE; spi_miso is then 0.
  - DONE: extra SCK edges are ignored and MISO stays 0. On CS rise, the transfer completes:
    - XFER_COUNT increments.
    - READ_FLAG[channel] is set (valid command only).
    - irq pulses if IRQ_EN=1.
    - If RAMP=1 and the command was valid, SAMPLE_CH[channel] += RAMP_STEP, mod 2^16.
    - Go to IDLE.
  - CS rise in CMD or DATA: abort. Set ABORT and go to IDLE. No count, flag, irq or ramp update.
- The sample snapshot is taken at the 8th command bit. A bus write to SAMPLE_CHn during DATA does not alter the bits already in flight.
- Simultaneous events:
  - A bus write to SAMPLE_CHn in the same cycle as a ramp update on the same channel: the bus write wins.
  - A W1C in the same cycle as a hardware set of the same bit: the set wins.
- ENABLE cleared mid-frame: behaves as an abort at that cycle. miso_oe and spi_miso go to 0.

## Timing
- Reset values:
  - Outputs: wb_dat_o=0, wb_ack=0, spi_miso=0, spi_miso_oe=0, irq=0.
  - Registers: CTRL=0, SAMPLE_CH*=0, RAMP_STEP=DEFAULT_STEP, XFER_COUNT=0, LAST_CMD=0, STATUS=0.
  - FSM in IDLE.
- Input-to-action latency is 3 clk from a pad edge: 2 synchronizer stages plus 1 edge register.
- spi_miso updates 3 clk after an SCK falling edge at the pad. The master must hold SCK half-period ≥ 4 clk, so MISO is stable ≥ 1 clk before the next rising edge.
- spi_miso_oe goes high 3 clk after CS fall and low 3 clk after CS rise.
- irq goes high for 1 clk, 4 clk after CS rise: 3 clk detection plus 1 registered.
- Register reads return data with wb_ack, 1 cycle after the stb is sampled.

## Test plan
- Write SAMPLE_CH2=0xA5C3, CTRL=0x1. Frame with command 0xC0 (ch2), 24 SCK at half-period 5 clk. Required: master samples 0xA5C3; LAST_CMD=0xC0; READ_FLAG=0x4; XFER_COUNT=1.
- CTRL=0x7, RAMP_STEP=0x0010, SAMPLE_CH0=0xFFF8. Two ch0 frames (cmd 0x80). Required: reads return 0xFFF8 then 0x0008 (wrap); irq pulses twice, 1 clk each.
- Command 0x40 (bit7=0). Required: 16 data bits all 0; CMD_ERR=1; XFER_COUNT increments; READ_FLAG unchanged. Writing STATUS=0x02 clears CMD_ERR.
- CS rises after 12 SCK cycles. Required: ABORT=1; XFER_COUNT, irq and ramp unchanged; BUSY=0 within 4 clk. The next full frame reads correctly.
- During DATA of a ch1 read (SAMPLE_CH1=0x1234), a bus write sets SAMPLE_CH1=0xFFFF. Required: master receives 0x1234; a subsequent read receives 0xFFFF.
- Assert rst_n low mid-DATA. Required: spi_miso=0, spi_miso_oe=0, all registers at reset values immediately; the next frame after reset release with ENABLE=1 works.
